// File: rtl/sat_counter_arbiter.sv
// Shared saturating up/down counter with a round-robin arbiter over NREQ requesters.
// A configuration port can load the counter or freeze arbitration.
module sat_counter_arbiter #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      NREQ    = 4,
    parameter logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SAT_MIN = '0,
    parameter int unsigned      IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_up,
    input  logic [NREQ*WIDTH-1:0] req_step,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  cfg_load,
    input  logic [WIDTH-1:0]      cfg_value,
    input  logic                  cfg_freeze,
    output logic [WIDTH-1:0]      count_out,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_sat
);

    typedef enum logic [1:0] {StRun, StHold, StLoad} mode_e;

    mode_e mode;

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic             resp_sat_q, resp_sat_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0] step_arr [NREQ];
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_up;
    logic [WIDTH-1:0] gnt_step;
    logic             accept;
    logic [WIDTH:0]   arith;
    logic             above, below;

    always_comb begin
        if (cfg_load) begin
            mode = StLoad;
        end else if (cfg_freeze) begin
            mode = StHold;
        end else begin
            mode = StRun;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            step_arr[i] = req_step[i*WIDTH +: WIDTH];
        end
    end

    // Search starts at rr_ptr and wraps modulo NREQ; first valid requester wins.
    always_comb begin : p_arb
        logic [IDW:0] pos;
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_up    = 1'b0;
        gnt_step  = '0;
        pos       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            idx = pos[IDW-1:0];
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
                gnt_up    = req_up[idx];
                gnt_step  = step_arr[idx];
            end
        end
    end

    assign accept = (mode == StRun) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // WIDTH+1 bit arithmetic: carry flags overflow, borrow flags a negative result.
    always_comb begin
        if (gnt_up) begin
            arith = {1'b0, count_q} + {1'b0, gnt_step};
        end else begin
            arith = {1'b0, count_q} - {1'b0, gnt_step};
        end
        above = gnt_up && (arith > {1'b0, SAT_MAX});
        below = !gnt_up && (arith[WIDTH] || (arith[WIDTH-1:0] < SAT_MIN));
    end

    always_comb begin
        count_d      = count_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_sat_d   = resp_sat_q;
        rr_ptr_d     = rr_ptr_q;
        unique case (mode)
            StLoad: begin
                if (cfg_value > SAT_MAX) begin
                    count_d = SAT_MAX;
                end else if (cfg_value < SAT_MIN) begin
                    count_d = SAT_MIN;
                end else begin
                    count_d = cfg_value;
                end
            end
            StHold: begin
                count_d = count_q;
            end
            StRun: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = gnt_idx;
                    rr_ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (above) begin
                        count_d    = SAT_MAX;
                        resp_sat_d = 1'b1;
                    end else if (below) begin
                        count_d    = SAT_MIN;
                        resp_sat_d = 1'b1;
                    end else begin
                        count_d    = arith[WIDTH-1:0];
                        resp_sat_d = 1'b0;
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
        at_max_d = (count_d == SAT_MAX);
        at_min_d = (count_d == SAT_MIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= SAT_MIN;
            at_max_q     <= (SAT_MIN == SAT_MAX);
            at_min_q     <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sat_q   <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            count_q      <= count_d;
            at_max_q     <= at_max_d;
            at_min_q     <= at_min_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sat_q   <= resp_sat_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign count_out  = count_q;
    assign at_max     = at_max_q;
    assign at_min     = at_min_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sat   = resp_sat_q;

endmodule

// File: doc/sat_counter_arbiter.md
# sat_counter_arbiter

Shares one saturating up/down counter between `NREQ` requesters. Each requester asks for a signed step (direction plus magnitude). A round-robin arbiter grants one request per cycle, and the block applies the step with clamping to `[SAT_MIN, SAT_MAX]`. A configuration port can load the counter or freeze arbitration. The block owns the counter register and sits between the requesting agents and any logic that consumes the shared count.

## Interface
- `WIDTH`, 8: counter and step width in bits.
- `NREQ`, 4: number of requesters, ≥2.
- `SAT_MAX`, 8'hFF: upper clamp, ≤ 2^WIDTH−1.
- `SAT_MIN`, 8'h00: lower clamp, < SAT_MAX.
- `IDW`, $clog2(NREQ): requester-id width, derived.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NREQ: bit i set means requester i has a pending step.
- `req_up` in NREQ: bit i is 1 for increment, 0 for decrement.
- `req_step` in NREQ*WIDTH: step magnitude for requester i in bits [i*WIDTH +: WIDTH], unsigned.
- `req_ready` out NREQ: one-hot grant; the request is accepted on an edge where `req_valid[i] && req_ready[i]`.
- `cfg_load` in 1: load `cfg_value` into the counter this cycle.
- `cfg_value` in WIDTH: load value, clamped into [SAT_MIN, SAT_MAX].
- `cfg_freeze` in 1: while high, no grants are issued.
- `count_out` out WIDTH: registered counter value.
- `at_max` / `at_min` out 1: registered, `count_out == SAT_MAX` / `== SAT_MIN`.
- `resp_valid` out 1: one-cycle pulse after each accepted request.
- `resp_id` out IDW: index of the requester the response belongs to.
- `resp_sat` out 1: the accepted step was clamped.

## Operation
- Reset (`rst_n` low, asynchronous) sets:
  - `count_out` = SAT_MIN, `at_min` = 1, `at_max` = 0.
  - `resp_valid` = 0, `resp_id` = 0, `resp_sat` = 0.
  - round-robin pointer `rr_ptr` = 0.
- Controller states:
  - RUN: grants allowed.
  - HOLD: `cfg_freeze` high; no grants.
  - LOAD: `cfg_load` high, for one cycle.
- State priority each cycle: `cfg_load` > `cfg_freeze` > arbitration.
- In LOAD and HOLD, `req_ready` = 0 on all bits and requests stay pending.
- LOAD next value: `count_out` ← clamp(`cfg_value`). No response is generated.
- Arbitration (RUN):
  - `req_ready` is combinational from `req_valid` and the registered `rr_ptr`.
  - The first set `req_valid` bit, searching i = `rr_ptr`, `rr_ptr`+1, … modulo NREQ, is granted.
  - At most one `req_ready` bit is high at a time.
- On accept of requester g:
  - `rr_ptr` ← (g+1) mod NREQ.
  - Arithmetic is done in WIDTH+1 bits: up → `count_out` + step; down → `count_out` − step.
  - If the result is > SAT_MAX, the counter becomes SAT_MAX and `resp_sat` = 1.
  - If the result is < SAT_MIN (including a negative result), the counter becomes SAT_MIN and `resp_sat` = 1.
  - Otherwise the counter takes the exact result and `resp_sat` = 0.
  - A step of 0 leaves the counter unchanged with `resp_sat` = 0.
- No valid requests: no grant, `rr_ptr` holds.
- Requesters must hold `req_valid`, `req_up` and `req_step` stable until accepted. Dropping `req_valid` before accept is allowed: the request is withdrawn and nothing is applied.
- `at_max` / `at_min` are recomputed from the next counter value and registered, so they always agree with `count_out`.

## Timing
- Cycle N, an edge where `req_valid[g] && req_ready[g]`: request accepted.
- Cycle N+1:
  - `count_out`, `at_max`, `at_min` show the new value.
  - `resp_valid` = 1 with `resp_id` = g and `resp_sat`.
- Throughput is one accepted request per cycle. Back-to-back accepts give back-to-back `resp_valid` pulses.
- The arbiter reads the current `count_out`, so request N+1 sees the result of request N.
- `cfg_load` at edge N gives the loaded value at N+1. `resp_valid` is 0 at N+1 unless it came from an accept at the previous edge.
- `cfg_freeze` takes effect the same cycle (combinational gating of `req_ready`). Releasing it allows a grant that same cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately. A pending `resp_valid` is discarded. On release, arbitration restarts from requester 0.

## Test plan
- Reset: `rst_n` low, then high → `count_out` = 0, `at_min` = 1, `resp_valid` = 0; first grant goes to the lowest valid index.
- Round-robin fairness: all 4 requesters valid, each up step 1, from 0 → grants in order 0,1,2,3,0; `count_out` 1,2,3,4,5 on successive cycles; `resp_id` matches each grant.
- Saturation: load 8'hFE, then req0 up step 5 → `count_out` = 8'hFF, `resp_sat` = 1, `at_max` = 1. Then req1 down step 8'h10 from 8'h05 (after load 5) → 0, `resp_sat` = 1, `at_min` = 1.
- Priority: `cfg_load` = 1 (value 8'h40) and `cfg_freeze` = 1 with req2 valid → `req_ready` = 0; count = 8'h40 next cycle; req2 is granted only after both drop.
- Clamped load: SAT_MAX = 8'hC0, `cfg_value` = 8'hF0 → `count_out` = 8'hC0, `at_max` = 1, no `resp_valid`.
- Mid-operation reset: continuous grants, assert `rst_n` low between edges → outputs reset asynchronously; after release, `rr_ptr` restarts at 0 and no stale `resp_valid` appears.
